// File: rtl/event_flag_collector_if.sv
// Write-port bundle between the event collector and a read-clear status register.
interface event_flag_collector_if #(
  parameter int NUM_LINES = 8
) ();
  logic                   IO_Busy;
  logic                   IO_WrEn;
  logic [2*NUM_LINES-1:0] IO_WrData;
  logic [2*NUM_LINES-1:0] IO_WrMask;

  modport master (
    input  IO_Busy,
    output IO_WrEn,
    output IO_WrData,
    output IO_WrMask
  );

  modport slave (
    output IO_Busy,
    input  IO_WrEn,
    input  IO_WrData,
    input  IO_WrMask
  );
endinterface

// File: rtl/event_flag_collector.sv
// Synchronises async lines, turns configured edges into sticky event/overrun flags
// and commits them as set-only masked writes into a read-clear status register.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | accumulate; commit {SO,SE} when anything pending and not busy
//   ISSUE   | strobe cycle just ended, drop data, clear timeout counter
//   WAIT_HI | wait for busy to rise, give up after BUSY_RISE_MAX cycles
//   WAIT_LO | wait for busy to fall before the next commit
module event_flag_collector #(
  parameter int                   NUM_LINES     = 8,
  parameter logic [NUM_LINES-1:0] EDGE_RISE     = '1,
  parameter logic [NUM_LINES-1:0] EDGE_FALL     = '0,
  parameter int                   SYNC_STAGES   = 2,
  parameter int                   BUSY_RISE_MAX = 4
) (
  input  logic                   IO_Clock,
  input  logic                   IO_Reset,
  input  logic [NUM_LINES-1:0]   Lines,
  event_flag_collector_if.master bus,
  output logic [2*NUM_LINES-1:0] Pending
);

  localparam int ARM_W = $clog2(SYNC_STAGES + 2);
  localparam int TMO_W = $clog2(BUSY_RISE_MAX + 1);
  localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(SYNC_STAGES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BUSY_RISE_MAX - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO} state_t;

  logic [NUM_LINES-1:0]   r_sync [SYNC_STAGES];
  logic [NUM_LINES-1:0]   r_prev;
  logic [ARM_W-1:0]       r_arm_cnt;
  logic [NUM_LINES-1:0]   r_pend;
  logic [NUM_LINES-1:0]   r_ovr;
  state_t                 r_state;
  logic [TMO_W-1:0]       r_tmo;
  logic                   r_wr_en;
  logic [2*NUM_LINES-1:0] r_wr_data;

  logic                 w_armed;
  logic [NUM_LINES-1:0] w_sync;
  logic [NUM_LINES-1:0] w_edge;
  logic [NUM_LINES-1:0] w_snap_e;
  logic [NUM_LINES-1:0] w_snap_o;

  assign w_armed  = (r_arm_cnt == ARM_DONE);
  assign w_sync   = r_sync[SYNC_STAGES-1];
  assign w_edge   = ((w_sync & ~r_prev & EDGE_RISE) | (~w_sync & r_prev & EDGE_FALL))
                    & {NUM_LINES{w_armed}};
  // Snapshot folds in this cycle's edges so nothing is lost when pending clears.
  assign w_snap_e = r_pend | w_edge;
  assign w_snap_o = r_ovr | (w_edge & r_pend);

  always_ff @(posedge IO_Clock) begin
    if (!IO_Reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_prev    <= '0;
      r_arm_cnt <= '0;
    end else begin
      r_sync[0] <= Lines;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_prev <= w_sync;
      if (!w_armed) r_arm_cnt <= r_arm_cnt + 1'b1;
    end
  end

  always_ff @(posedge IO_Clock) begin
    if (!IO_Reset) begin
      r_pend    <= '0;
      r_ovr     <= '0;
      r_state   <= IDLE;
      r_tmo     <= '0;
      r_wr_en   <= 1'b0;
      r_wr_data <= '0;
    end else begin
      r_pend <= r_pend | w_edge;
      r_ovr  <= r_ovr | (w_edge & r_pend);
      case (r_state)
        IDLE: begin
          if ((w_snap_e != '0) && !bus.IO_Busy) begin
            r_wr_en   <= 1'b1;
            r_wr_data <= {w_snap_o, w_snap_e};
            r_pend    <= '0;
            r_ovr     <= '0;
            r_state   <= ISSUE;
          end else begin
            r_wr_en   <= 1'b0;
            r_wr_data <= '0;
          end
        end
        ISSUE: begin
          r_wr_en   <= 1'b0;
          r_wr_data <= '0;
          r_tmo     <= '0;
          r_state   <= WAIT_HI;
        end
        WAIT_HI: begin
          if (bus.IO_Busy || (r_tmo == TMO_LAST)) r_state <= WAIT_LO;
          else                                    r_tmo   <= r_tmo + 1'b1;
        end
        WAIT_LO: begin
          if (!bus.IO_Busy) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.IO_WrEn   = r_wr_en;
  assign bus.IO_WrData = r_wr_data;
  assign bus.IO_WrMask = r_wr_data;
  assign Pending       = {r_ovr, r_pend};

endmodule
